// File: rtl/sccb_target.sv
// sccb_target: SCCB slave exposing a 256 x 8 register file, a host readback port and a write strobe.
// Define SCCB_TARGET_ACK_EN to drive an I2C-style ACK in the 9th slot after matched ID/SUB/WDATA bytes.
module sccb_target (
   input  logic       clk50,
   input  logic       reset,
   input  logic       sio_c,
   input  logic       sio_d_in,
   output logic       sio_d_oe,
   output logic       wr_valid,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       busy,
   input  logic [7:0] host_addr,
   output logic [7:0] host_rdata
);

   localparam logic [7:0] DEVICE_ID = 8'h42;

`ifdef SCCB_TARGET_ACK_EN
   localparam logic ACK_EN = 1'b1;
`else
   localparam logic ACK_EN = 1'b0;
`endif

   localparam logic [3:0] S_IDLE      = 4'd0;
   localparam logic [3:0] S_ID        = 4'd1;
   localparam logic [3:0] S_ID_ACK    = 4'd2;
   localparam logic [3:0] S_SUB       = 4'd3;
   localparam logic [3:0] S_SUB_ACK   = 4'd4;
   localparam logic [3:0] S_WDATA     = 4'd5;
   localparam logic [3:0] S_WDATA_ACK = 4'd6;
   localparam logic [3:0] S_RDATA     = 4'd7;
   localparam logic [3:0] S_RDATA_ACK = 4'd8;
   localparam logic [3:0] S_IGNORE    = 4'd9;

   logic       scl_s1_q, scl_s2_q, scl_h_q;
   logic       sda_s1_q, sda_s2_q, sda_h_q;
   logic       scl_rise, scl_fall, start_det, stop_det;

   logic [3:0] state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic [6:0] shift_q, shift_d;
   logic       ackr_q, ackr_d;
   logic       rd_id_q, rd_id_d;
   logic [7:0] ptr_q, ptr_d;
   logic       oe_q, oe_d;
   logic       busy_q, busy_d;
   logic       wr_valid_q;
   logic [7:0] wr_addr_q, wr_data_q;
   logic [7:0] host_rdata_q;
   logic       commit;
   logic [7:0] byte_in;
   logic [7:0] rd_byte;

   logic [7:0] regfile [256];

   // Synchronizers idle high so a reset never fabricates a START/STOP edge.
   always_ff @(posedge clk50) begin
      if (reset) begin
         scl_s1_q <= 1'b1;
         scl_s2_q <= 1'b1;
         scl_h_q  <= 1'b1;
         sda_s1_q <= 1'b1;
         sda_s2_q <= 1'b1;
         sda_h_q  <= 1'b1;
      end else begin
         scl_s1_q <= sio_c;
         scl_s2_q <= scl_s1_q;
         scl_h_q  <= scl_s2_q;
         sda_s1_q <= sio_d_in;
         sda_s2_q <= sda_s1_q;
         sda_h_q  <= sda_s2_q;
      end
   end

   assign scl_rise  = scl_s2_q & ~scl_h_q;
   assign scl_fall  = ~scl_s2_q & scl_h_q;
   assign start_det = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
   assign stop_det  = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;

   assign byte_in = {shift_q, sda_s2_q};
   assign rd_byte = regfile[ptr_q];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      ackr_d  = ackr_q;
      rd_id_d = rd_id_q;
      ptr_d   = ptr_q;
      oe_d    = oe_q;
      busy_d  = busy_q;
      commit  = 1'b0;
      if (start_det) begin
         state_d = S_ID;
         cnt_d   = '0;
         ackr_d  = 1'b0;
         oe_d    = 1'b0;
         busy_d  = 1'b1;
      end else if (stop_det) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         ackr_d  = 1'b0;
         oe_d    = 1'b0;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            S_ID, S_SUB, S_WDATA: begin
               if (scl_rise) begin
                  shift_d = byte_in[6:0];
                  cnt_d   = cnt_q + 3'd1;
                  if (cnt_q == 3'd7) begin
                     ackr_d = 1'b0;
                     if (state_q == S_ID) begin
                        if (byte_in[7:1] == DEVICE_ID[7:1]) begin
                           state_d = S_ID_ACK;
                           rd_id_d = byte_in[0];
                        end else begin
                           state_d = S_IGNORE;
                        end
                     end else if (state_q == S_SUB) begin
                        ptr_d   = byte_in;
                        state_d = S_SUB_ACK;
                     end else begin
                        commit  = ~reset;
                        state_d = S_WDATA_ACK;
                     end
                  end
               end
            end
            // First fall opens the 9th slot, the rise inside it arms ackr, the next fall closes it.
            S_ID_ACK, S_SUB_ACK, S_WDATA_ACK: begin
               if (scl_rise) begin
                  ackr_d = 1'b1;
               end else if (scl_fall) begin
                  if (!ackr_q) begin
                     oe_d = ACK_EN;
                  end else begin
                     ackr_d = 1'b0;
                     oe_d   = 1'b0;
                     if (state_q == S_ID_ACK) begin
                        if (rd_id_q) begin
                           state_d = S_RDATA;
                           cnt_d   = '0;
                           oe_d    = ~rd_byte[7];
                        end else begin
                           state_d = S_SUB;
                        end
                     end else if (state_q == S_SUB_ACK) begin
                        state_d = S_WDATA;
                     end else begin
                        state_d = S_IGNORE;
                     end
                  end
               end
            end
            S_RDATA: begin
               if (scl_rise) begin
                  cnt_d = cnt_q + 3'd1;
                  if (cnt_q == 3'd7) state_d = S_RDATA_ACK;
               end else if (scl_fall) begin
                  oe_d = ~rd_byte[3'd7 - cnt_q];
               end
            end
            S_RDATA_ACK: begin
               if (scl_fall) begin
                  oe_d = 1'b0;
               end else if (scl_rise) begin
                  if (sda_s2_q) begin
                     state_d = S_IGNORE;
                  end else begin
                     state_d = S_RDATA;
                     cnt_d   = '0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk50) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         shift_q    <= '0;
         ackr_q     <= 1'b0;
         rd_id_q    <= 1'b0;
         ptr_q      <= '0;
         oe_q       <= 1'b0;
         busy_q     <= 1'b0;
         wr_valid_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         ackr_q     <= ackr_d;
         rd_id_q    <= rd_id_d;
         ptr_q      <= ptr_d;
         oe_q       <= oe_d;
         busy_q     <= busy_d;
         wr_valid_q <= commit;
         if (commit) begin
            wr_addr_q <= ptr_q;
            wr_data_q <= byte_in;
         end
      end
   end

   always_ff @(posedge clk50) begin
      if (commit) regfile[ptr_q] <= byte_in;
   end

   // Nonblocking read alongside the write gives read-before-write on an address collision.
   always_ff @(posedge clk50) begin
      if (reset) host_rdata_q <= '0;
      else       host_rdata_q <= regfile[host_addr];
   end

   assign sio_d_oe   = oe_q;
   assign wr_valid   = wr_valid_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign busy       = busy_q;
   assign host_rdata = host_rdata_q;

endmodule

// File: tb/tb_sccb_target.sv
// tb_sccb_target: directed SCCB master transactions against sccb_target with immediate-assertion checks.
module tb_sccb_target;

`ifdef SCCB_TARGET_ACK_EN
   localparam logic ACK_EXP = 1'b1;
`else
   localparam logic ACK_EXP = 1'b0;
`endif

   logic       clk;
   logic       reset;
   logic       scl_m;
   logic       sda_m;
   logic       sio_d_in;
   logic       sio_d_oe;
   logic       wr_valid;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic       busy;
   logic [7:0] host_addr;
   logic [7:0] host_rdata;

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned wr_cnt = 0;
   int unsigned oe_hi  = 0;
   logic [7:0]  last_addr = '0;
   logic [7:0]  last_data = '0;

   // Open-drain bus: the target can only pull the line low.
   assign sio_d_in = sda_m & ~sio_d_oe;

   sccb_target dut (
      .clk50      (clk),
      .reset      (reset),
      .sio_c      (scl_m),
      .sio_d_in   (sio_d_in),
      .sio_d_oe   (sio_d_oe),
      .wr_valid   (wr_valid),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .busy       (busy),
      .host_addr  (host_addr),
      .host_rdata (host_rdata)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   always @(negedge clk) begin
      if (wr_valid === 1'b1) begin
         wr_cnt++;
         last_addr = wr_addr;
         last_data = wr_data;
      end
      if (sio_d_oe === 1'b1) oe_hi++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_start();
      if (scl_m == 1'b0) begin
         cyc(5); sda_m = 1'b1;
         cyc(5); scl_m = 1'b1;
      end
      cyc(5);  sda_m = 1'b0;
      cyc(10); scl_m = 1'b0;
   endtask

   task automatic do_stop();
      cyc(5); sda_m = 1'b0;
      cyc(5); scl_m = 1'b1;
      cyc(5); sda_m = 1'b1;
      cyc(10);
   endtask

   task automatic send_bit(input logic b);
      cyc(5);  sda_m = b;
      cyc(5);  scl_m = 1'b1;
      cyc(10); scl_m = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] v, output logic ack_oe);
      for (int i = 7; i >= 0; i--) send_bit(v[i]);
      cyc(5); sda_m = 1'b1;
      cyc(5); scl_m = 1'b1;
      cyc(5); ack_oe = sio_d_oe;
      cyc(5); scl_m = 1'b0;
   endtask

   task automatic recv_bit(output logic b, output logic oe);
      cyc(5); sda_m = 1'b1;
      cyc(5); scl_m = 1'b1;
      cyc(5); b = sio_d_in; oe = sio_d_oe;
      cyc(5); scl_m = 1'b0;
   endtask

   task automatic recv_byte(output logic [7:0] v, output logic [7:0] pat);
      logic b, oe;
      v = '0;
      pat = '0;
      for (int i = 0; i < 8; i++) begin
         recv_bit(b, oe);
         v   = {v[6:0], b};
         pat = {pat[6:0], oe};
      end
   endtask

   task automatic host_read(input logic [7:0] a, output logic [7:0] d);
      host_addr = a;
      cyc(1);
      d = host_rdata;
   endtask

   initial begin
      logic       a0, a1, a2, bb, oo;
      logic [7:0] rb, pat, hd;
      int unsigned oe_base;

      reset = 1'b1;
      scl_m = 1'b1;
      sda_m = 1'b1;
      host_addr = '0;
      cyc(4);
      chk("rst_oe", sio_d_oe, 0);
      chk("rst_wr_valid", wr_valid, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_host_rdata", host_rdata, 0);
      reset = 1'b0;
      cyc(5);

      // 3-phase write 0x12 <= 0x80
      do_start();
      chk("busy_after_start", busy, 1);
      send_byte(8'h42, a0);
      send_byte(8'h12, a1);
      send_byte(8'h80, a2);
      do_stop();
      chk("w1_ack_id", a0, ACK_EXP);
      chk("w1_ack_sub", a1, ACK_EXP);
      chk("w1_ack_data", a2, ACK_EXP);
      chk("w1_wr_cnt", wr_cnt, 1);
      chk("w1_addr", last_addr, 8'h12);
      chk("w1_data", last_data, 8'h80);
      chk("w1_busy_after_stop", busy, 0);
      host_read(8'h12, hd);
      chk("w1_host", hd, 8'h80);

      // 2-phase write then read with NA
      do_start();
      send_byte(8'h42, a0);
      send_byte(8'h12, a1);
      do_stop();
      do_start();
      send_byte(8'h43, a0);
      recv_byte(rb, pat);
      send_bit(1'b1);
      do_stop();
      chk("rd_ack_id", a0, ACK_EXP);
      chk("rd_byte", rb, 8'h80);
      chk("rd_oe_pattern", pat, 8'h7F);
      chk("rd_no_write", wr_cnt, 1);
      chk("rd_busy_after_stop", busy, 0);

      // Wrong ID: no ACK, no write, pin never pulled
      oe_base = oe_hi;
      do_start();
      send_byte(8'h60, a0);
      send_byte(8'h12, a1);
      send_byte(8'h55, a2);
      do_stop();
      chk("wid_ack0", a0, 0);
      chk("wid_ack1", a1, 0);
      chk("wid_ack2", a2, 0);
      chk("wid_oe_cycles", oe_hi - oe_base, 0);
      chk("wid_wr_cnt", wr_cnt, 1);
      chk("wid_busy", busy, 0);

      // Repeated START after four SUB bits
      do_start();
      send_byte(8'h42, a0);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
      do_start();
      send_byte(8'h42, a0);
      send_byte(8'h3A, a1);
      send_byte(8'h04, a2);
      do_stop();
      chk("rs_wr_cnt", wr_cnt, 2);
      chk("rs_addr", last_addr, 8'h3A);
      chk("rs_data", last_data, 8'h04);
      host_read(8'h3A, hd);
      chk("rs_host_3a", hd, 8'h04);
      host_read(8'h12, hd);
      chk("rs_host_12", hd, 8'h80);

      // Reset during bit 3 of a read of 0x12
      do_start();
      send_byte(8'h42, a0);
      send_byte(8'h12, a1);
      do_stop();
      do_start();
      send_byte(8'h43, a0);
      recv_bit(bb, oo);
      recv_bit(bb, oo);
      cyc(8);
      chk("mr_oe_before_reset", sio_d_oe, 1);
      reset = 1'b1;
      cyc(1);
      chk("mr_oe_after_reset", sio_d_oe, 0);
      chk("mr_busy_after_reset", busy, 0);
      chk("mr_state_idle", dut.state_q, 0);
      reset = 1'b0;
      do_start();
      send_byte(8'h42, a0);
      send_byte(8'h11, a1);
      send_byte(8'h01, a2);
      do_stop();
      chk("mr_wr_cnt", wr_cnt, 3);
      chk("mr_addr", last_addr, 8'h11);
      chk("mr_data", last_data, 8'h01);
      host_read(8'h11, hd);
      chk("mr_host", hd, 8'h01);

      // Extra byte ignored; then a read repeated by master ACK
      do_start();
      send_byte(8'h42, a0);
      send_byte(8'h20, a1);
      send_byte(8'h5A, a2);
      send_byte(8'h66, a2);
      do_stop();
      chk("xb_wr_cnt", wr_cnt, 4);
      chk("xb_data", last_data, 8'h5A);
      host_read(8'h20, hd);
      chk("xb_host", hd, 8'h5A);
      do_start();
      send_byte(8'h42, a0);
      send_byte(8'h20, a1);
      do_stop();
      do_start();
      send_byte(8'h43, a0);
      recv_byte(rb, pat);
      chk("rr_first", rb, 8'h5A);
      send_bit(1'b0);
      recv_byte(rb, pat);
      chk("rr_second", rb, 8'h5A);
      chk("rr_second_oe", pat, 8'hA5);
      send_bit(1'b1);
      do_stop();
      chk("rr_no_write", wr_cnt, 4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
